resonator_chain: RTL and testbench
==================================

RESONATOR_CHAIN -- requirements
Module: resonator_chain

Interface
REQ-001 SHALL have parameter NSEC, default 6, meaning number of cascaded second-order all-pole sections (1..8).
REQ-002 SHALL have clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have rst_an  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have sample_in  input  16  signed excitation sample from the source stage.
REQ-005 SHALL have strobe  input  1  sample-rate strobe; a rising edge requests one filter evaluation.
REQ-006 SHALL have coef_we  input  1  coefficient write enable.
REQ-007 SHALL have coef_addr  input  4  coefficient index: 2*s = a1 of section s, 2*s+1 = a2 of section s.
REQ-008 SHALL have coef_data  input  10  signed Q1.8 coefficient (-2.0 .. +1.996).
REQ-009 SHALL have clear_state  input  1  synchronous clear of all section delay registers.
REQ-010 SHALL have filter_out  output  16  signed filtered sample.
REQ-011 SHALL have out_valid  output  1  one-cycle pulse when filter_out updates.
REQ-012 SHALL have busy  output  1  high while an evaluation is in progress.
REQ-013 SHALL have overrun  output  1  sticky flag: strobe edge arrived while busy.

Function
REQ-014 Strobe edge SHALL be detected as strobe==1 with registered previous strobe==0; sample_in is captured in that same cycle and busy rises next cycle.
REQ-015 FSM states SHALL be IDLE, MAC_A1, MAC_A2, UPDATE, DONE; IDLE->MAC_A1 on edge; MAC_A1->MAC_A2->UPDATE per section; UPDATE->MAC_A1 (next section) or DONE after section NSEC-1; DONE->IDLE.
REQ-016 One shared signed 16x10 multiplier SHALL be used, one product per MAC cycle.
REQ-017 Per section s: acc = (x_s <<< 8) + a1_s*y1_s + a2_s*y2_s, acc 28-bit signed, no intermediate overflow.
REQ-018 y_s SHALL equal acc >>> 8 (arithmetic, truncating) saturated to [-32768, 32767].
REQ-019 In UPDATE: y2_s <= y1_s, y1_s <= y_s; x_(s+1) = y_s.
REQ-020 In DONE: filter_out <= y_(NSEC-1), out_valid=1 for exactly that cycle; latency = 3*NSEC+1 cycles after capture edge (19 for NSEC=6).
REQ-021 filter_out SHALL hold its value between out_valid pulses.
REQ-022 Strobe edge while busy SHALL be ignored (no capture) and set overrun; overrun clears only on reset or clear_state.
REQ-023 Coefficient writes SHALL take effect next cycle when busy==0; writes while busy==1 SHALL be dropped; coef_addr >= 2*NSEC ignored.
REQ-024 clear_state SHALL zero all y1/y2, clear overrun, abort any evaluation to IDLE with no out_valid; it has priority over a same-cycle strobe edge; coefficients retained.

Reset
REQ-025 On rst_an low: filter_out=0, out_valid=0, busy=0, overrun=0, FSM=IDLE, all y1/y2=0, all coefficients=0, previous-strobe=0.
REQ-026 Reset mid-evaluation SHALL discard the evaluation; first edge after release is evaluated normally.

Structure
REQ-027 Shared package SHALL hold FSM state enumeration, coefficient width (10), fraction bits (8), sample width (16), accumulator width (28).
REQ-028 One sub-module, sat16 (28-bit signed in, shift-and-saturate to 16-bit out), SHALL be instantiated.

Verification
REQ-029 All coefficients 0, sample_in=1234, strobe edge -> out_valid 19 cycles later, filter_out=1234.
REQ-030 Section 0 a1=128 (0.5), others 0; samples 1000,0,0 on successive edges -> outputs 1000, 500, 250.
REQ-031 Section 0 a1=-256 (-1.0), a2=0; sample 32767 then 32767 -> outputs 32767, 0; then a1=255, samples 32767,32767 -> second output saturates to 32767.
REQ-032 Second strobe edge 5 cycles after first -> single out_valid, overrun=1, result equals single-sample result; clear_state -> overrun=0, y1/y2=0.
REQ-033 coef_we during busy with a1=128 -> output unchanged from all-zero-coefficient case; rst_an low at cycle 10 of evaluation -> no out_valid, all outputs 0.

Source files
------------

// File: rtl/resonator_chain_pkg.sv
// Shared types and fixed-point widths for the cascaded all-pole resonator chain.
package resonator_chain_pkg;
  localparam int SAMPLE_W = 16;
  localparam int COEF_W   = 10;
  localparam int FRAC_W   = 8;
  localparam int ACC_W    = 28;
  localparam int PROD_W   = SAMPLE_W + COEF_W;
  localparam int SEC_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC_A1,
    ST_MAC_A2,
    ST_UPDATE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/resonator_chain_sat16.sv
// Drops the Q.8 fraction of an accumulator (arithmetic, truncating) and clamps to 16 bits.
module sat16
  import resonator_chain_pkg::*;
(
  input  logic signed [ACC_W-1:0]    acc_i,
  output logic signed [SAMPLE_W-1:0] y_o
);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_V = -ACC_W'(32768);

  logic signed [ACC_W-1:0] sh;

  always_comb begin
    sh = acc_i >>> FRAC_W;
    if (sh > MAX_V)      y_o = 16'sh7fff;
    else if (sh < MIN_V) y_o = 16'sh8000;
    else                 y_o = sh[SAMPLE_W-1:0];
  end
endmodule

// File: rtl/resonator_chain.sv
// NSEC cascaded second-order all-pole sections evaluated serially on one shared 16x10 multiplier.
module resonator_chain
  import resonator_chain_pkg::*;
#(
  parameter int NSEC = 6
) (
  input  logic                       clk,
  input  logic                       rst_an,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       strobe,
  input  logic                       coef_we,
  input  logic [3:0]                 coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       clear_state,
  output logic signed [SAMPLE_W-1:0] filter_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);
  localparam logic [4:0]       NCOEF    = 5'(2 * NSEC);
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NSEC - 1);

  state_e                     state_q, state_d;
  logic [SEC_W-1:0]           sec_q, sec_d;
  logic                       strobe_prev_q, strobe_prev_d;
  logic signed [SAMPLE_W-1:0] x_q, x_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [SAMPLE_W-1:0] filter_out_q, filter_out_d;
  logic                       out_valid_q, out_valid_d;
  logic                       overrun_q, overrun_d;
  logic signed [SAMPLE_W-1:0] y1_q [NSEC];
  logic signed [SAMPLE_W-1:0] y1_d [NSEC];
  logic signed [SAMPLE_W-1:0] y2_q [NSEC];
  logic signed [SAMPLE_W-1:0] y2_d [NSEC];
  logic signed [COEF_W-1:0]   a1_q [NSEC];
  logic signed [COEF_W-1:0]   a1_d [NSEC];
  logic signed [COEF_W-1:0]   a2_q [NSEC];
  logic signed [COEF_W-1:0]   a2_d [NSEC];

  logic                       strobe_edge;
  logic signed [SAMPLE_W-1:0] mul_y;
  logic signed [COEF_W-1:0]   mul_c;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    x_sh;
  logic signed [SAMPLE_W-1:0] y_sat;

  assign strobe_edge = strobe & ~strobe_prev_q;
  assign busy        = (state_q != ST_IDLE);
  assign filter_out  = filter_out_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;

  // MAC_A1 multiplies by the y1/a1 pair, MAC_A2 by y2/a2; one product per cycle.
  always_comb begin
    if (state_q == ST_MAC_A2) begin
      mul_y = y2_q[sec_q];
      mul_c = a2_q[sec_q];
    end else begin
      mul_y = y1_q[sec_q];
      mul_c = a1_q[sec_q];
    end
  end

  assign prod     = PROD_W'(mul_y) * PROD_W'(mul_c);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign x_sh     = {{(ACC_W - SAMPLE_W - FRAC_W){x_q[SAMPLE_W-1]}}, x_q, {FRAC_W{1'b0}}};

  sat16 u_sat (
    .acc_i (acc_q),
    .y_o   (y_sat)
  );

  always_comb begin
    state_d       = state_q;
    sec_d         = sec_q;
    strobe_prev_d = strobe;
    x_d           = x_q;
    acc_d         = acc_q;
    filter_out_d  = filter_out_q;
    out_valid_d   = 1'b0;
    overrun_d     = overrun_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    a1_d          = a1_q;
    a2_d          = a2_q;

    if (!busy && coef_we && ({1'b0, coef_addr} < NCOEF)) begin
      if (coef_addr[0]) a2_d[coef_addr[3:1]] = coef_data;
      else              a1_d[coef_addr[3:1]] = coef_data;
    end

    // Clear wins over everything else, including a strobe edge in the same cycle.
    if (clear_state) begin
      state_d   = ST_IDLE;
      sec_d     = '0;
      overrun_d = 1'b0;
      for (int i = 0; i < NSEC; i++) begin
        y1_d[i] = '0;
        y2_d[i] = '0;
      end
    end else begin
      if (strobe_edge && busy) overrun_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (strobe_edge) begin
            x_d     = sample_in;
            sec_d   = '0;
            state_d = ST_MAC_A1;
          end
        end
        ST_MAC_A1: begin
          acc_d   = x_sh + prod_ext;
          state_d = ST_MAC_A2;
        end
        ST_MAC_A2: begin
          acc_d   = acc_q + prod_ext;
          state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          y2_d[sec_q] = y1_q[sec_q];
          y1_d[sec_q] = y_sat;
          x_d         = y_sat;
          if (sec_q == LAST_SEC) begin
            state_d = ST_DONE;
          end else begin
            sec_d   = sec_q + 1'b1;
            state_d = ST_MAC_A1;
          end
        end
        ST_DONE: begin
          filter_out_d = y1_q[NSEC-1];
          out_valid_d  = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q       <= ST_IDLE;
      sec_q         <= '0;
      strobe_prev_q <= 1'b0;
      x_q           <= '0;
      acc_q         <= '0;
      filter_out_q  <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NSEC; i++) begin
        y1_q[i] <= '0;
        y2_q[i] <= '0;
        a1_q[i] <= '0;
        a2_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      sec_q         <= sec_d;
      strobe_prev_q <= strobe_prev_d;
      x_q           <= x_d;
      acc_q         <= acc_d;
      filter_out_q  <= filter_out_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      a1_q          <= a1_d;
      a2_q          <= a2_d;
    end
  end
endmodule

// File: tb/tb_resonator_chain.sv
// Directed, table-driven bench for resonator_chain (NSEC=6) with hand-computed expectations.
module tb_resonator_chain;
  logic               clk = 1'b0;
  logic               rst_an = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               strobe = 1'b0;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [9:0]  coef_data = '0;
  logic               clear_state = 1'b0;
  logic signed [15:0] filter_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  resonator_chain #(.NSEC(6)) dut (
    .clk         (clk),
    .rst_an      (rst_an),
    .sample_in   (sample_in),
    .strobe      (strobe),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .clear_state (clear_state),
    .filter_out  (filter_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int sec;
    int a1;
    int a2;
    bit clr;
    int smp;
    int exp;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wcoef(input int addr, input int val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 10'(val);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
  endtask

  task automatic zero_coefs();
    for (int i = 0; i < 12; i++) wcoef(i, 0);
  endtask

  // Fire one edge; the edge is the posedge following the negedge drive.
  task automatic fire(input int smp);
    @(negedge clk);
    sample_in = 16'(smp);
    strobe    = 1'b1;
    @(posedge clk);
    #1;
    strobe    = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit got);
    n   = 1;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      if (out_valid) got = 1'b1;
      else n++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
  endtask

  task automatic run_sample(input string nm, input int smp, input int exp);
    int  n;
    bit  got;
    fire(smp);
    chk({nm, "_busy"}, int'(busy), 1);
    wait_valid(n, got);
    chk({nm, "_lat"}, got ? n : -1, 19);
    chk({nm, "_val"}, int'(filter_out), exp);
    @(posedge clk);
    #1;
    chk({nm, "_pulse1"}, int'(out_valid), 0);
    chk({nm, "_hold"}, int'(filter_out), exp);
  endtask

  initial begin
    int n;
    bit got;
    int pulses;
    int v;

    tbl[0]  = '{0,    0,   0, 1'b1,   1234,   1234};
    tbl[1]  = '{0,  128,   0, 1'b1,   1000,   1000};
    tbl[2]  = '{0,  128,   0, 1'b0,      0,    500};
    tbl[3]  = '{0,  128,   0, 1'b0,      0,    250};
    tbl[4]  = '{0, -256,   0, 1'b1,  32767,  32767};
    tbl[5]  = '{0, -256,   0, 1'b0,  32767,      0};
    tbl[6]  = '{0,  255,   0, 1'b0,  32767,  32767};
    tbl[7]  = '{0,  255,   0, 1'b0,  32767,  32767};
    tbl[8]  = '{0,    0, 128, 1'b1,   1000,   1000};
    tbl[9]  = '{0,    0, 128, 1'b0,      0,      0};
    tbl[10] = '{0,    0, 128, 1'b0,      0,    500};
    tbl[11] = '{5,  128,   0, 1'b1,  -1000,  -1000};
    tbl[12] = '{5,  128,   0, 1'b0,      0,   -500};
    tbl[13] = '{0,  255,   0, 1'b1, -32768, -32768};
    tbl[14] = '{0,  255,   0, 1'b0, -32768, -32768};
    tbl[15] = '{0,  128,   0, 1'b1,     -1,     -1};
    tbl[16] = '{0,  128,   0, 1'b0,      0,     -1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_filter_out", int'(filter_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(negedge clk);
    rst_an = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].clr) begin
        do_clear();
        zero_coefs();
      end
      wcoef(2 * tbl[i].sec, tbl[i].a1);
      wcoef(2 * tbl[i].sec + 1, tbl[i].a2);
      run_sample($sformatf("vec%0d", i), tbl[i].smp, tbl[i].exp);
    end

    // Second edge five cycles into an evaluation is dropped and flagged.
    do_clear();
    zero_coefs();
    fire(1234);
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_before", int'(overrun), 0);
    fire(999);
    chk("ovr_set", int'(overrun), 1);
    pulses = 0;
    v = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        v = int'(filter_out);
      end
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_val", v, 1234);
    chk("ovr_sticky", int'(overrun), 1);
    do_clear();
    chk("ovr_cleared", int'(overrun), 0);

    // clear_state empties the delay lines: with a1=0.5 a zero input must give 0.
    wcoef(0, 128);
    run_sample("clr_pre", 1000, 1000);
    do_clear();
    run_sample("clr_post", 0, 0);

    // Coefficient write during busy is dropped.
    zero_coefs();
    fire(1234);
    @(posedge clk);
    #1;
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 10'sd128;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    wait_valid(n, got);
    chk("cbusy_seen", int'(got), 1);
    chk("cbusy_val", int'(filter_out), 1234);
    run_sample("cbusy_next", 0, 0);

    // Out-of-range coefficient address leaves section 0 untouched.
    wcoef(12, 128);
    wcoef(13, 128);
    run_sample("oob_a", 1000, 1000);
    run_sample("oob_b", 0, 0);

    // clear_state mid-evaluation aborts with no output pulse.
    fire(500);
    repeat (4) @(posedge clk);
    #1;
    clear_state = 1'b1;
    @(posedge clk);
    #1;
    clear_state = 1'b0;
    chk("abort_busy", int'(busy), 0);
    count_pulses(30, pulses);
    chk("abort_pulses", pulses, 0);

    // clear_state beats a same-cycle strobe edge.
    @(negedge clk);
    clear_state = 1'b1;
    strobe      = 1'b1;
    sample_in   = 16'sd4321;
    @(posedge clk);
    #1;
    clear_state = 1'b0;
    strobe      = 1'b0;
    chk("clr_edge_busy", int'(busy), 0);
    count_pulses(25, pulses);
    chk("clr_edge_pulses", pulses, 0);

    // Reset at cycle 10 of an evaluation discards it and wipes coefficients.
    wcoef(0, 128);
    run_sample("rstm_pre", 1000, 1000);
    fire(777);
    repeat (9) @(posedge clk);
    #1;
    rst_an = 1'b0;
    #1;
    chk("rstm_filter_out", int'(filter_out), 0);
    chk("rstm_busy", int'(busy), 0);
    chk("rstm_out_valid", int'(out_valid), 0);
    chk("rstm_overrun", int'(overrun), 0);
    count_pulses(3, pulses);
    @(negedge clk);
    rst_an = 1'b1;
    count_pulses(25, v);
    chk("rstm_pulses", pulses + v, 0);
    run_sample("rstm_post", 777, 777);
    run_sample("rstm_coef0", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
